// File: rtl/arf_ckpt_bank.sv
// Architectural register file for the retire stage with a checkpoint bank.
// Multi-port retire writes, read-first/write-through reads, 1-cycle save, chunked restore.
module arf_ckpt_bank #(
  parameter int DATA_W       = 32,
  parameter int AREG_NUM     = 32,
  parameter int RD_PORTS     = 4,
  parameter int WR_PORTS     = 2,
  parameter int CKPT_NUM     = 2,
  parameter int COPY_PER_CYC = 8,
  localparam int IDW         = $clog2(AREG_NUM),
  localparam int CKW         = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [WR_PORTS-1:0]          wr_valid,
  input  logic [WR_PORTS*IDW-1:0]      wr_id,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  input  logic [RD_PORTS*IDW-1:0]      rd_id,
  input  logic [RD_PORTS-1:0]          rd_mode,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic                         save_valid,
  input  logic [CKW-1:0]               save_idx,
  input  logic                         rest_valid,
  input  logic [CKW-1:0]               rest_idx,
  output logic                         ready,
  output logic                         busy,
  output logic                         rest_done
);

  localparam int NCHUNK = AREG_NUM / COPY_PER_CYC;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic {S_IDLE, S_RESTORE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CKW-1:0]    idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] regs_q [AREG_NUM];
  logic [DATA_W-1:0] regs_d [AREG_NUM];
  logic [DATA_W-1:0] ckpt_q [CKPT_NUM][AREG_NUM];
  logic [DATA_W-1:0] ckpt_d [CKPT_NUM][AREG_NUM];
  logic [DATA_W-1:0] wr_img [AREG_NUM];
  logic              save_ok, rest_ok;

  // Post-write image: ascending port order lets the highest port win on id collisions.
  // NOTE: blocking '=' in always_comb so later loop iterations see earlier results.
  always_comb begin
    for (int i = 0; i < AREG_NUM; i++) wr_img[i] = regs_q[i];
    if (state_q == S_IDLE) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_valid[p] && (wr_id[p*IDW +: IDW] != '0) &&
            (int'(wr_id[p*IDW +: IDW]) < AREG_NUM))
          wr_img[wr_id[p*IDW +: IDW]] = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      if ((rd_id[r*IDW +: IDW] != '0) && (int'(rd_id[r*IDW +: IDW]) < AREG_NUM))
        rd_data[r*DATA_W +: DATA_W] = rd_mode[r] ? wr_img[rd_id[r*IDW +: IDW]]
                                                 : regs_q[rd_id[r*IDW +: IDW]];
    end
  end

  // A valid restore request takes precedence over a same-cycle save.
  assign rest_ok = rest_valid && (int'(rest_idx) < CKPT_NUM);
  assign save_ok = save_valid && !rest_ok && (int'(save_idx) < CKPT_NUM);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    ckpt_d  = ckpt_q;
    case (state_q)
      S_IDLE: begin
        regs_d = wr_img;
        if (save_ok) ckpt_d[save_idx] = wr_img;
        if (rest_ok) begin
          state_d = S_RESTORE;
          cnt_d   = '0;
          idx_d   = rest_idx;
        end
      end
      S_RESTORE: begin
        for (int i = 0; i < AREG_NUM; i++) begin
          if ((i / COPY_PER_CYC) == int'(cnt_q)) regs_d[i] = ckpt_q[idx_q][i];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CHUNK) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the register image and checkpoint slots must read as zero after reset,
  // so these arrays are cleared explicitly instead of being left to a RAM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < AREG_NUM; i++) regs_q[i] <= '0;
      for (int k = 0; k < CKPT_NUM; k++)
        for (int i = 0; i < AREG_NUM; i++) ckpt_q[k][i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
      ckpt_q  <= ckpt_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = ~ready;
  assign rest_done = done_q;

endmodule

// File: tb/tb_arf_ckpt_bank.sv
// Directed bench for arf_ckpt_bank: reads/writes, save/restore, collisions, reset mid-restore.
module tb_arf_ckpt_bank;
  localparam int DW = 32, AN = 32, RP = 4, WP = 2, CN = 2, CP = 8;
  localparam int IDW = 5, CKW = 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic [WP-1:0]     wr_valid;
  logic [WP*IDW-1:0] wr_id;
  logic [WP*DW-1:0]  wr_data;
  logic [RP*IDW-1:0] rd_id;
  logic [RP-1:0]     rd_mode;
  logic [RP*DW-1:0]  rd_data;
  logic              save_valid, rest_valid;
  logic [CKW-1:0]    save_idx, rest_idx;
  logic              ready, busy, rest_done;

  int total = 0;
  int bad   = 0;

  arf_ckpt_bank #(.DATA_W(DW), .AREG_NUM(AN), .RD_PORTS(RP), .WR_PORTS(WP),
                  .CKPT_NUM(CN), .COPY_PER_CYC(CP)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_id(wr_id), .wr_data(wr_data),
    .rd_id(rd_id), .rd_mode(rd_mode), .rd_data(rd_data), .save_valid(save_valid),
    .save_idx(save_idx), .rest_valid(rest_valid), .rest_idx(rest_idx),
    .ready(ready), .busy(busy), .rest_done(rest_done));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wr_valid = '0; wr_id = '0; wr_data = '0;
    save_valid = 1'b0; save_idx = '0; rest_valid = 1'b0; rest_idx = '0;
  endtask

  task automatic set_wr(input int p, input int id, input logic [DW-1:0] d);
    wr_valid[p]          = 1'b1;
    wr_id[p*IDW +: IDW]  = IDW'(id);
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic rd(input int p, input int id, input bit m, output logic [DW-1:0] v);
    rd_id[p*IDW +: IDW] = IDW'(id);
    rd_mode[p]          = m;
    #1;
    v = rd_data[p*DW +: DW];
  endtask

  // Writes regs 1..AN-1 with either their own index or a constant, two per cycle.
  task automatic fill(input bit use_index, input logic [DW-1:0] val);
    for (int i = 1; i < AN; i += 2) begin
      set_wr(0, i, use_index ? DW'(i) : val);
      if (i + 1 < AN) set_wr(1, i + 1, use_index ? DW'(i + 1) : val);
      tick();
      idle_inputs();
    end
  endtask

  task automatic run_restore(input int slot);
    rest_valid = 1'b1;
    rest_idx   = CKW'(slot);
    tick();
    idle_inputs();
    repeat (AN / CP + 1) tick();
  endtask

  task automatic test_reset;
    logic [DW-1:0] v;
    idle_inputs();
    rd_id = '0; rd_mode = '0;
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rest_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", rest_done); end
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < RP; p++)
        for (int i = 0; i < AN; i++) begin
          rd(p, i, m[0], v);
          total++;
          if (v !== '0) begin bad++; $display("FAIL reset_rd p%0d id%0d m%0d: got %h want 0", p, i, m, v); end
        end
  endtask

  task automatic test_write_priority;
    logic [DW-1:0] v;
    set_wr(0, 5, 32'h0000_AAAA);
    set_wr(1, 5, 32'h0000_5555);
    rd(0, 5, 1'b1, v);
    total++; if (v !== 32'h5555) begin bad++; $display("FAIL wt_same_cycle: got %h want 00005555", v); end
    rd(1, 5, 1'b0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rf_same_cycle: got %h want 0", v); end
    tick();
    idle_inputs();
    rd(2, 5, 1'b1, v);
    total++; if (v !== 32'h5555) begin bad++; $display("FAIL wt_next_cycle: got %h want 00005555", v); end
    rd(3, 5, 1'b0, v);
    total++; if (v !== 32'h5555) begin bad++; $display("FAIL rf_next_cycle: got %h want 00005555", v); end
  endtask

  task automatic test_reg_zero;
    logic [DW-1:0] v;
    set_wr(0, 0, 32'hFFFF_FFFF);
    set_wr(1, 0, 32'hFFFF_FFFF);
    for (int p = 0; p < RP; p++) begin
      rd(p, 0, p[0], v);
      total++; if (v !== '0) begin bad++; $display("FAIL zero_same p%0d: got %h want 0", p, v); end
    end
    tick();
    idle_inputs();
    for (int m = 0; m < 2; m++) begin
      rd(0, 0, m[0], v);
      total++; if (v !== '0) begin bad++; $display("FAIL zero_after m%0d: got %h want 0", m, v); end
    end
  endtask

  task automatic test_save_restore;
    logic [DW-1:0] v, exp;
    int nbusy, ndone;
    fill(1'b1, '0);
    set_wr(0, 3, 32'h33);
    save_valid = 1'b1; save_idx = 1'b1;
    tick();
    idle_inputs();
    fill(1'b0, 32'hDEAD);
    rd(0, 3, 1'b0, v);
    total++; if (v !== 32'hDEAD) begin bad++; $display("FAIL overwrite_r3: got %h want 0000dead", v); end
    rest_valid = 1'b1; rest_idx = 1'b1;
    tick();
    idle_inputs();
    nbusy = 0; ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy) nbusy++;
      if (rest_done) ndone++;
      tick();
    end
    total++; if (nbusy !== 4) begin bad++; $display("FAIL busy_cycles: got %0d want 4", nbusy); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL done_pulses: got %0d want 1", ndone); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after: got %b want 1", ready); end
    for (int i = 0; i < AN; i++) begin
      rd(i % RP, i, 1'b0, v);
      exp = (i == 3) ? 32'h33 : DW'(i);
      total++; if (v !== exp) begin bad++; $display("FAIL restored id%0d: got %h want %h", i, v, exp); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [DW-1:0] v;
    fill(1'b0, 32'hBEEF);
    // Start cycle: restore wins over save; the same-cycle write still commits.
    rest_valid = 1'b1; rest_idx = 1'b1;
    save_valid = 1'b1; save_idx = 1'b0;
    set_wr(0, 30, 32'h1234);
    tick();
    idle_inputs();
    set_wr(0, 5, 32'h77); set_wr(1, 29, 32'h77);
    save_valid = 1'b1; save_idx = 1'b0;
    rest_valid = 1'b1; rest_idx = 1'b0;
    tick();
    rd(0, 5, 1'b0, v);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL mid_chunk0_rf: got %h want 5", v); end
    rd(1, 5, 1'b1, v);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL mid_chunk0_wt: got %h want 5", v); end
    rd(2, 29, 1'b1, v);
    total++; if (v !== 32'hBEEF) begin bad++; $display("FAIL mid_chunk3_r29: got %h want 0000beef", v); end
    rd(3, 30, 1'b0, v);
    total++; if (v !== 32'h1234) begin bad++; $display("FAIL mid_chunk3_r30: got %h want 00001234", v); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    repeat (3) tick();
    idle_inputs();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL busy_end_ready: got %b want 1", ready); end
    total++; if (rest_done !== 1'b1) begin bad++; $display("FAIL busy_end_done: got %b want 1", rest_done); end
    rd(0, 29, 1'b0, v);
    total++; if (v !== 32'd29) begin bad++; $display("FAIL end_r29: got %h want 1d", v); end
    rd(1, 30, 1'b0, v);
    total++; if (v !== 32'd30) begin bad++; $display("FAIL end_r30: got %h want 1e", v); end
    rd(2, 5, 1'b0, v);
    total++; if (v !== 32'd5) begin bad++; $display("FAIL end_r5: got %h want 5", v); end
    rd(3, 3, 1'b0, v);
    total++; if (v !== 32'h33) begin bad++; $display("FAIL end_r3: got %h want 33", v); end
    tick();
    run_restore(0);
    rd(0, 5, 1'b0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL slot0_r5: got %h want 0", v); end
    rd(1, 30, 1'b0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL slot0_r30: got %h want 0", v); end
  endtask

  task automatic test_reset_mid_restore;
    logic [DW-1:0] v;
    int ndone;
    fill(1'b1, '0);
    set_wr(0, 9, 32'h99);
    save_valid = 1'b1; save_idx = 1'b0;
    tick();
    idle_inputs();
    rest_valid = 1'b1; rest_idx = 1'b1;
    tick();
    idle_inputs();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (rest_done) ndone++;
      tick();
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL rst_mid_done: got %0d want 0", ndone); end
    for (int i = 0; i < AN; i++) begin
      rd(i % RP, i, 1'b0, v);
      total++; if (v !== '0) begin bad++; $display("FAIL rst_mid_reg id%0d: got %h want 0", i, v); end
    end
    run_restore(0);
    rd(0, 9, 1'b0, v);
    total++; if (v !== '0) begin bad++; $display("FAIL rst_slot0_r9: got %h want 0", v); end
    run_restore(1);
    rd(1, 3, 1'b0, v);
    total++; if (v !== '0) begin bad++; $display("FAIL rst_slot1_r3: got %h want 0", v); end
    rd(2, 20, 1'b0, v);
    total++; if (v !== '0) begin bad++; $display("FAIL rst_slot1_r20: got %h want 0", v); end
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_reg_zero();
    test_save_restore();
    test_busy_ignore();
    test_reset_mid_restore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
